// File: rtl/framebuffer_arbiter_pkg.sv
// framebuffer_arbiter_pkg
// Shared types and constants for the framebuffer arbiter.
//   clear_state_t   : clear sequencer states
//   rd_tag_t        : owner tag carried alongside each issued memory read
//   STALL_CNT_WIDTH : width of the optional per-requester stall counters
//   sat_inc         : saturating increment used by the stall counters
package framebuffer_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clear_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    DISP = 2'd1,
    HOST = 2'd2
  } rd_tag_t;

  localparam int STALL_CNT_WIDTH = 16;

  function automatic logic [STALL_CNT_WIDTH-1:0] sat_inc(input logic [STALL_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + STALL_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/framebuffer_arbiter_if.sv
// framebuffer_arbiter_if
// Bundles every handshake/bus signal of the framebuffer arbiter:
//   write requesters : wr_valid / wr_addr / wr_data / wr_ready (packed per requester)
//   display reader   : disp_rd_en / disp_rd_addr / disp_rd_valid / disp_rd_data
//   host reader      : host_rd_valid / host_rd_addr / host_rd_ready / host_rsp_valid / host_rsp_data
//   clear control    : clear_start / clear_value / clear_busy / clear_done
//   memory side      : mem_write_en/addr/data, mem_read_en/addr, mem_read_data
// Modports: slave = the arbiter, master = requesters plus the memory instance.
interface framebuffer_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_SIZE  = 8,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]            wr_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_REQ*WORD_SIZE-1:0]  wr_data;
  logic [NUM_REQ-1:0]            wr_ready;
  logic                          disp_rd_en;
  logic [ADDR_WIDTH-1:0]         disp_rd_addr;
  logic                          disp_rd_valid;
  logic [WORD_SIZE-1:0]          disp_rd_data;
  logic                          host_rd_valid;
  logic [ADDR_WIDTH-1:0]         host_rd_addr;
  logic                          host_rd_ready;
  logic                          host_rsp_valid;
  logic [WORD_SIZE-1:0]          host_rsp_data;
  logic                          clear_start;
  logic [WORD_SIZE-1:0]          clear_value;
  logic                          clear_busy;
  logic                          clear_done;
  logic                          mem_write_en;
  logic [ADDR_WIDTH-1:0]         mem_write_addr;
  logic [WORD_SIZE-1:0]          mem_write_data;
  logic                          mem_read_en;
  logic [ADDR_WIDTH-1:0]         mem_read_addr;
  logic [WORD_SIZE-1:0]          mem_read_data;

  modport slave (
    input  wr_valid, wr_addr, wr_data, disp_rd_en, disp_rd_addr,
           host_rd_valid, host_rd_addr, clear_start, clear_value, mem_read_data,
    output wr_ready, disp_rd_valid, disp_rd_data, host_rd_ready, host_rsp_valid,
           host_rsp_data, clear_busy, clear_done, mem_write_en, mem_write_addr,
           mem_write_data, mem_read_en, mem_read_addr
  );

  modport master (
    output wr_valid, wr_addr, wr_data, disp_rd_en, disp_rd_addr,
           host_rd_valid, host_rd_addr, clear_start, clear_value, mem_read_data,
    input  wr_ready, disp_rd_valid, disp_rd_data, host_rd_ready, host_rsp_valid,
           host_rsp_data, clear_busy, clear_done, mem_write_en, mem_write_addr,
           mem_write_data, mem_read_en, mem_read_addr
  );
endinterface

// File: rtl/framebuffer_arbiter_rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter with a rotating priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i      : request vector
//   advance_i  : a grant was consumed this cycle; pointer moves past it
//   grant_o    : one-hot (or zero) grant, combinational from req_i
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [2*NUM_REQ-1:0] req_dbl, gnt_dbl;
  logic [NUM_REQ-1:0]   req_rot, gnt_rot;

  // Rotate so the pointer position sits at bit 0, keep the lowest set bit,
  // then rotate back; the doubled vectors make the wrap free.
  assign req_dbl = {req_i, req_i} >> ptr_q;
  assign req_rot = req_dbl[NUM_REQ-1:0];
  assign gnt_rot = req_rot & (-req_rot);
  assign gnt_dbl = {{NUM_REQ{1'b0}}, gnt_rot} << ptr_q;
  assign grant_o = gnt_dbl[NUM_REQ-1:0] | gnt_dbl[2*NUM_REQ-1:NUM_REQ];

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (advance_i && grant_o[i]) begin
        ptr_d = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter
// Shares one simple dual-port framebuffer (1-cycle registered read) between
// NUM_REQ round-robin write requesters, a display reader (strict read
// priority) and a host reader, and owns a clear sequencer that fills
// NUM_WORDS locations with a constant. All memory ports are registered.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : framebuffer_arbiter_if.slave (requesters, readers, clear, memory)
//   stall_count : NUM_REQ x 16-bit saturating stall counters, only when
//                 FRAMEBUFFER_ARBITER_STATS_EN is defined
module framebuffer_arbiter
  import framebuffer_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_SIZE  = 8,
  parameter int NUM_WORDS  = 256,
  parameter int NUM_REQ    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  framebuffer_arbiter_if.slave  bus
`ifdef FRAMEBUFFER_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*STALL_CNT_WIDTH-1:0] stall_count
`endif
);
  // One extra bit so NUM_WORDS == 2**ADDR_WIDTH finishes without wrapping.
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(NUM_WORDS - 1);

  clear_state_t          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]  clr_val_q, clr_val_d;
  logic                  run_q;
  logic [NUM_REQ-1:0]    arb_req, grant;
  logic                  we_d, we_q;
  logic [ADDR_WIDTH-1:0] waddr_d, waddr_q;
  logic [WORD_SIZE-1:0]  wdata_d, wdata_q;
  rd_tag_t               tag_d, tag1_q, tag2_q;
  logic [ADDR_WIDTH-1:0] raddr_d, raddr_q;
  logic                  done_q;

  // run_q keeps every combinational handshake output low while in reset.
  assign arb_req = (run_q && state_q == IDLE) ? bus.wr_valid : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (arb_req),
    .advance_i (|grant),
    .grant_o   (grant)
  );

  assign bus.wr_ready = grant;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_val_d = clr_val_q;
    we_d      = 1'b0;
    waddr_d   = '0;
    wdata_d   = '0;
    unique case (state_q)
      IDLE: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant[i]) begin
            we_d    = 1'b1;
            waddr_d = bus.wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_d = bus.wr_data[i*WORD_SIZE +: WORD_SIZE];
          end
        end
        if (bus.clear_start) begin
          state_d   = CLEAR;
          cnt_d     = '0;
          clr_val_d = bus.clear_value;
        end
      end
      CLEAR: begin
        we_d    = 1'b1;
        waddr_d = cnt_q[ADDR_WIDTH-1:0];
        wdata_d = clr_val_q;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ADDR) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Display always wins the read port; the tag follows the read so the
  // returning word is steered to whoever issued it.
  assign bus.host_rd_ready = run_q & ~bus.disp_rd_en;

  always_comb begin
    tag_d   = NONE;
    raddr_d = bus.host_rd_addr;
    if (bus.disp_rd_en) begin
      tag_d   = DISP;
      raddr_d = bus.disp_rd_addr;
    end else if (bus.host_rd_valid && bus.host_rd_ready) begin
      tag_d   = HOST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      clr_val_q <= '0;
      run_q     <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      tag1_q    <= NONE;
      tag2_q    <= NONE;
      raddr_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_val_q <= clr_val_d;
      run_q     <= 1'b1;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      tag1_q    <= tag_d;
      tag2_q    <= tag1_q;
      raddr_q   <= raddr_d;
      done_q    <= (state_q == DONE);
    end
  end

  assign bus.mem_write_en   = we_q;
  assign bus.mem_write_addr = waddr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_read_en    = (tag1_q != NONE);
  assign bus.mem_read_addr  = raddr_q;
  assign bus.disp_rd_valid  = (tag2_q == DISP);
  assign bus.disp_rd_data   = (tag2_q == DISP) ? bus.mem_read_data : '0;
  assign bus.host_rsp_valid = (tag2_q == HOST);
  assign bus.host_rsp_data  = (tag2_q == HOST) ? bus.mem_read_data : '0;
  assign bus.clear_busy     = (state_q != IDLE);
  assign bus.clear_done     = done_q;

`ifdef FRAMEBUFFER_ARBITER_STATS_EN
  logic [NUM_REQ-1:0][STALL_CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.wr_valid[i] && !bus.wr_ready[i]) stall_q[i] <= sat_inc(stall_q[i]);
      end
    end
  end

  assign stall_count = stall_q;
`endif
endmodule
